// File: rtl/cdb_complete_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_complete_arbiter_if
//   Request/grant bundle between the completing functional units and the
//   CDB completion arbiter.
//
//   Signals
//     req              : per-requester completion request, {fixed, variable}
//     ovf_clear        : synchronous clear of fixed_overflow
//     complete_gnt_bus : [lane][requester] grant matrix, one-hot or zero per lane
//     var_gnt          : grants returned to the variable-latency units
//     lanes_used       : number of lanes granted this cycle
//     fixed_overflow   : sticky "too many fixed-latency completions" flag
//     rr_ptr           : current round-robin start (debug)
//
//   Modports
//     master : requester side (drives req / ovf_clear)
//     slave  : arbiter side
// -----------------------------------------------------------------------------
interface cdb_complete_arbiter_if #(
  parameter int N         = 2,
  parameter int NUM_VAR   = 4,
  parameter int NUM_FIXED = 4
);
  localparam int NUM_REQ = NUM_VAR + NUM_FIXED;
  localparam int PTR_W   = (NUM_VAR > 1) ? $clog2(NUM_VAR) : 1;
  localparam int LU_W    = $clog2(N + 1);

  logic [NUM_REQ-1:0]        req;
  logic                      ovf_clear;
  logic [N-1:0][NUM_REQ-1:0] complete_gnt_bus;
  logic [NUM_VAR-1:0]        var_gnt;
  logic [LU_W-1:0]           lanes_used;
  logic                      fixed_overflow;
  logic [PTR_W-1:0]          rr_ptr;

  modport master (
    output req, ovf_clear,
    input  complete_gnt_bus, var_gnt, lanes_used, fixed_overflow, rr_ptr
  );

  modport slave (
    input  req, ovf_clear,
    output complete_gnt_bus, var_gnt, lanes_used, fixed_overflow, rr_ptr
  );
endinterface

// File: rtl/cdb_complete_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_complete_arbiter
//   Completion-bus arbiter for the execute stage. Fixed-latency requesters
//   (ALU, branch; indices [NUM_REQ-1:NUM_VAR]) are always served first in
//   ascending index order. Variable-latency requesters (load buffer, mult;
//   indices [NUM_VAR-1:0]) fill the remaining lanes.
//
//   Optional feature macro: CDB_ARB_RR_EN
//     defined   : variable requesters are scanned round-robin from rr_ptr,
//                 which moves one past the last variable requester granted.
//     undefined : variable requesters use fixed priority from index 0;
//                 rr_ptr is tied to 0 and has no register.
//
//   Ports
//     clock : single clock
//     reset : asynchronous, active-high; grants are forced to zero while high
//     bus   : cdb_complete_arbiter_if.slave (see interface header)
//
//   Grant outputs are purely combinational from req and rr_ptr.
// -----------------------------------------------------------------------------
module cdb_complete_arbiter #(
  parameter int N         = 2,
  parameter int NUM_VAR   = 4,
  parameter int NUM_FIXED = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  cdb_complete_arbiter_if.slave  bus
);
  localparam int NUM_REQ = NUM_VAR + NUM_FIXED;
  localparam int PTR_W   = (NUM_VAR > 1) ? $clog2(NUM_VAR) : 1;
  localparam int LU_W    = $clog2(N + 1);
  localparam int LANE_IW = (N > 1) ? $clog2(N) : 1;

  // Grant matrix kept as separate fixed/variable halves so each half can be
  // indexed with a selector sized exactly to it.
  logic [N-1:0][NUM_FIXED-1:0] w_fix_gnt;
  logic [N-1:0][NUM_VAR-1:0]   w_var_lane_gnt;
  logic [NUM_VAR-1:0]          w_var_req;
  logic [NUM_VAR-1:0]          w_var_any;
  logic [PTR_W-1:0]            w_rr_ptr;
  logic [PTR_W-1:0]            w_idx;
  int                          w_lane_cnt;
  int                          w_fixed_cnt;
  logic                        w_ovf_set;
  logic                        r_fixed_overflow;

  assign w_var_req = bus.req[NUM_VAR-1:0];

  // ---------------------------------------------------------------------------
  // Lane allocation: fixed requesters first, then variable in scan order.
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in a combinational block gets a default at
  // the top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_fix_gnt      = '0;
    w_var_lane_gnt = '0;
    w_lane_cnt     = 0;
    w_fixed_cnt    = 0;
    w_idx          = '0;

    for (int f = 0; f < NUM_FIXED; f++) begin
      if (bus.req[NUM_VAR+f]) begin
        w_fixed_cnt = w_fixed_cnt + 1;
        // Beyond N lanes the remaining fixed results are dropped.
        if (w_lane_cnt < N) begin
          w_fix_gnt[w_lane_cnt[LANE_IW-1:0]][f] = 1'b1;
          w_lane_cnt = w_lane_cnt + 1;
        end
      end
    end

    for (int k = 0; k < NUM_VAR; k++) begin
      w_idx = PTR_W'((int'(w_rr_ptr) + k) % NUM_VAR);
      if (w_var_req[w_idx] && (w_lane_cnt < N)) begin
        w_var_lane_gnt[w_lane_cnt[LANE_IW-1:0]][w_idx] = 1'b1;
        w_lane_cnt = w_lane_cnt + 1;
      end
    end
  end

  // Grants back to the variable-latency units (before reset masking).
  always_comb begin
    w_var_any = '0;
    for (int l = 0; l < N; l++) begin
      w_var_any = w_var_any | w_var_lane_gnt[l];
    end
  end

  assign w_ovf_set = (w_fixed_cnt > N);

  // ---------------------------------------------------------------------------
  // Outputs: reset forces every grant output to zero regardless of req.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.complete_gnt_bus = '0;
    bus.var_gnt          = '0;
    bus.lanes_used       = '0;
    if (!reset) begin
      for (int l = 0; l < N; l++) begin
        bus.complete_gnt_bus[l] = {w_fix_gnt[l], w_var_lane_gnt[l]};
      end
      bus.var_gnt    = w_var_any;
      bus.lanes_used = LU_W'(w_lane_cnt);
    end
  end

  assign bus.rr_ptr         = w_rr_ptr;
  assign bus.fixed_overflow = r_fixed_overflow;

  // ---------------------------------------------------------------------------
  // Rotation pointer
  // ---------------------------------------------------------------------------
`ifdef CDB_ARB_RR_EN
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] w_rr_next;
  logic [PTR_W-1:0] w_scan_idx;

  // Walk the same scan order as the allocator; the last granted index seen
  // wins, so the pointer lands one past the last requester served.
  always_comb begin
    w_rr_next  = r_rr_ptr;
    w_scan_idx = '0;
    for (int k = 0; k < NUM_VAR; k++) begin
      w_scan_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_VAR);
      if (w_var_any[w_scan_idx]) begin
        w_rr_next = PTR_W'((int'(w_scan_idx) + 1) % NUM_VAR);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else begin
      r_rr_ptr <= w_rr_next;
    end
  end

  assign w_rr_ptr = r_rr_ptr;
`else
  // Fixed priority: scanning always starts at index 0.
  assign w_rr_ptr = '0;
`endif

  // ---------------------------------------------------------------------------
  // Sticky overflow flag: a new overflow takes precedence over a clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fixed_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_fixed_overflow <= 1'b1;
    end else if (bus.ovf_clear) begin
      r_fixed_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_complete_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_complete_arbiter
//   Directed, table-driven bench for cdb_complete_arbiter with N=2,
//   NUM_VAR=4, NUM_FIXED=4. Each vector row carries the expected results for
//   both builds (round-robin and fixed-priority); the build selects the
//   column. Reset and mid-operation reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_cdb_complete_arbiter;

`ifdef CDB_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  cdb_complete_arbiter_if #(.N(2), .NUM_VAR(4), .NUM_FIXED(4)) bus ();

  cdb_complete_arbiter #(.N(2), .NUM_VAR(4), .NUM_FIXED(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] req;
    logic       clr;
    logic [7:0] l0_rr;
    logic [7:0] l1_rr;
    logic [3:0] var_rr;
    logic [1:0] ptr_rr;
    logic [7:0] l0_fp;
    logic [7:0] l1_fp;
    logic [3:0] var_fp;
    logic [1:0] lu;
    logic       ovf;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_grants(input string tag, input logic [7:0] l0, input logic [7:0] l1,
                              input logic [3:0] vg, input logic [1:0] lu);
    check({tag, " lane0"}, 32'(bus.complete_gnt_bus[0]), 32'(l0));
    check({tag, " lane1"}, 32'(bus.complete_gnt_bus[1]), 32'(l1));
    check({tag, " var_gnt"}, 32'(bus.var_gnt), 32'(vg));
    check({tag, " lanes_used"}, 32'(bus.lanes_used), 32'(lu));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // req, clr, l0_rr, l1_rr, var_rr, ptr_rr, l0_fp, l1_fp, var_fp, lanes, ovf
    vecs[0]  = '{8'h0F, 1'b0, 8'h01, 8'h02, 4'h3, 2'd2, 8'h01, 8'h02, 4'h3, 2'd2, 1'b0};
    vecs[1]  = '{8'h0F, 1'b0, 8'h04, 8'h08, 4'hC, 2'd0, 8'h01, 8'h02, 4'h3, 2'd2, 1'b0};
    vecs[2]  = '{8'h0F, 1'b0, 8'h01, 8'h02, 4'h3, 2'd2, 8'h01, 8'h02, 4'h3, 2'd2, 1'b0};
    vecs[3]  = '{8'h08, 1'b0, 8'h08, 8'h00, 4'h8, 2'd0, 8'h08, 8'h00, 4'h8, 2'd1, 1'b0};
    vecs[4]  = '{8'h16, 1'b0, 8'h10, 8'h02, 4'h2, 2'd2, 8'h10, 8'h02, 4'h2, 2'd2, 1'b0};
    vecs[5]  = '{8'h00, 1'b0, 8'h00, 8'h00, 4'h0, 2'd2, 8'h00, 8'h00, 4'h0, 2'd0, 1'b0};
    vecs[6]  = '{8'h04, 1'b0, 8'h04, 8'h00, 4'h4, 2'd3, 8'h04, 8'h00, 4'h4, 2'd1, 1'b0};
    vecs[7]  = '{8'h09, 1'b0, 8'h08, 8'h01, 4'h9, 2'd1, 8'h01, 8'h08, 4'h9, 2'd2, 1'b0};
    vecs[8]  = '{8'h70, 1'b0, 8'h10, 8'h20, 4'h0, 2'd1, 8'h10, 8'h20, 4'h0, 2'd2, 1'b1};
    vecs[9]  = '{8'h00, 1'b0, 8'h00, 8'h00, 4'h0, 2'd1, 8'h00, 8'h00, 4'h0, 2'd0, 1'b1};
    vecs[10] = '{8'h00, 1'b1, 8'h00, 8'h00, 4'h0, 2'd1, 8'h00, 8'h00, 4'h0, 2'd0, 1'b0};
    vecs[11] = '{8'hF0, 1'b1, 8'h10, 8'h20, 4'h0, 2'd1, 8'h10, 8'h20, 4'h0, 2'd2, 1'b1};
    vecs[12] = '{8'h30, 1'b1, 8'h10, 8'h20, 4'h0, 2'd1, 8'h10, 8'h20, 4'h0, 2'd2, 1'b0};
    vecs[13] = '{8'h1F, 1'b0, 8'h10, 8'h02, 4'h2, 2'd2, 8'h10, 8'h01, 4'h1, 2'd2, 1'b0};
    vecs[14] = '{8'hFF, 1'b0, 8'h10, 8'h20, 4'h0, 2'd2, 8'h10, 8'h20, 4'h0, 2'd2, 1'b1};

    bus.req       = 8'h00;
    bus.ovf_clear = 1'b0;

    // ---- Reset with every request asserted ----
    #1;
    reset   = 1'b1;
    bus.req = 8'hFF;
    #2;
    check_grants("reset", 8'h00, 8'h00, 4'h0, 2'd0);
    check("reset rr_ptr", 32'(bus.rr_ptr), 32'd0);
    check("reset ovf", 32'(bus.fixed_overflow), 32'd0);
    @(posedge clock); #1;
    check("reset edge lane0", 32'(bus.complete_gnt_bus[0]), 32'h0);
    check("reset edge ovf", 32'(bus.fixed_overflow), 32'd0);

    // ---- Deassert: grants appear in the same cycle ----
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_grants("post-reset", 8'h10, 8'h20, 4'h0, 2'd2);
    check("post-reset rr_ptr", 32'(bus.rr_ptr), 32'd0);
    @(posedge clock); #1;
    check("post-reset ovf set", 32'(bus.fixed_overflow), 32'd1);
    check("post-reset rr_ptr hold", 32'(bus.rr_ptr), 32'd0);
    @(negedge clock);
    bus.req       = 8'h00;
    bus.ovf_clear = 1'b1;
    @(posedge clock); #1;
    check("ovf clear", 32'(bus.fixed_overflow), 32'd0);

    // ---- Table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      bus.req       = vecs[i].req;
      bus.ovf_clear = vecs[i].clr;
      #1;
      if (RR_MODE) begin
        check_grants($sformatf("v%0d", i), vecs[i].l0_rr, vecs[i].l1_rr, vecs[i].var_rr, vecs[i].lu);
      end else begin
        check_grants($sformatf("v%0d", i), vecs[i].l0_fp, vecs[i].l1_fp, vecs[i].var_fp, vecs[i].lu);
      end
      @(posedge clock); #1;
      check($sformatf("v%0d rr_ptr", i), 32'(bus.rr_ptr), RR_MODE ? 32'(vecs[i].ptr_rr) : 32'd0);
      check($sformatf("v%0d ovf", i), 32'(bus.fixed_overflow), 32'(vecs[i].ovf));
    end

    // ---- Mid-operation reset between edges ----
    @(negedge clock);
    bus.req       = 8'h0F;
    bus.ovf_clear = 1'b0;
    #1;
    if (RR_MODE) check_grants("pre-midreset", 8'h04, 8'h08, 4'hC, 2'd2);
    else         check_grants("pre-midreset", 8'h01, 8'h02, 4'h3, 2'd2);
    #1;
    reset = 1'b1;
    #1;
    check_grants("midreset", 8'h00, 8'h00, 4'h0, 2'd0);
    check("midreset rr_ptr", 32'(bus.rr_ptr), 32'd0);
    check("midreset ovf", 32'(bus.fixed_overflow), 32'd0);
    reset = 1'b0;
    #1;
    check_grants("after midreset", 8'h01, 8'h02, 4'h3, 2'd2);
    @(posedge clock); #1;
    check("after midreset rr_ptr", 32'(bus.rr_ptr), RR_MODE ? 32'd2 : 32'd0);
    check("after midreset ovf", 32'(bus.fixed_overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cdb_complete_arbiter.md
# cdb_complete_arbiter

Completion-bus arbiter feeding the execute stage. It takes per-functional-unit completion requests and drives `complete_gnt_bus`, the one-hot-per-lane grant matrix the execute stage uses to route `fu_result` onto the `N` CDB lanes. It also drives the per-unit grant vector that returns to the variable-latency units (`mult_cdb_gnt`, `load_cdb_gnt`). Requester index order matches the execute-stage `fu_result` packing `{branch, alu, mult, load}`: load occupies the low indices and branch the high indices.

## Interface
- `N`, default 2 — number of CDB lanes.
- `NUM_VAR`, default 4 — variable-latency requesters (load buffer entries plus mult units) at indices `[NUM_VAR-1:0]`.
- `NUM_FIXED`, default 4 — fixed-latency requesters (ALU plus branch) at indices `[NUM_REQ-1:NUM_VAR]`.
- `NUM_REQ`, default `NUM_VAR+NUM_FIXED` — derived; not overridable.
- `clock` in 1 — the single clock.
- `reset` in 1 — asynchronous, active-high.
- `req` in `NUM_REQ` — completion request per requester, level-valid for the cycle.
- `ovf_clear` in 1 — synchronous clear of `fixed_overflow`.
- `complete_gnt_bus` out `[N-1:0][NUM_REQ-1:0]` — lane `i` grant; one-hot or zero.
- `var_gnt` out `NUM_VAR` — OR of `complete_gnt_bus` over lanes, restricted to the variable-latency requesters.
- `lanes_used` out `$clog2(N+1)` — count of lanes granted this cycle.
- `fixed_overflow` out 1 — sticky error flag: more than `N` fixed-latency requests arrived in one cycle.
- `rr_ptr` out `$clog2(NUM_VAR)` — current rotation start, exposed for debug.

## Operation
- **Fixed-latency requesters.** Their results exist for one cycle only, so they are always served first.
  - Set fixed request bits are granted in ascending index order into lanes 0, 1, … .
  - If more than `N` fixed requests are set, the lowest-index `N` are granted and the rest are dropped.
  - In that case `fixed_overflow` is set on the next edge.
- **Variable-latency requesters.** They fill the remaining lanes.
  - Scan starts at `rr_ptr` and ascends modulo `NUM_VAR`.
  - Grants go into the next free lane in ascending lane order.
- **Grant exclusivity.**
  - No requester is granted on more than one lane.
  - Each lane has at most one grant.
  - Unused lanes are all-zero.
- **Rotation pointer.**
  - `rr_ptr` next = (index of the last variable requester granted this cycle + 1) mod `NUM_VAR`.
  - "Last" means the last one in scan order.
  - If no variable requester was granted, `rr_ptr` holds.
- **Ungranted variable requesters** keep their request asserted; the arbiter holds no per-request state.
- **`fixed_overflow`.**
  - Sets when fixed request popcount > `N`.
  - Clears on `ovf_clear` when no overflow occurs in the same cycle; set wins over clear.
  - Clears on `reset`.
- **`lanes_used`** = popcount of granted requesters (at most `N`).

## Timing
- All grant outputs (`complete_gnt_bus`, `var_gnt`, `lanes_used`) are combinational from `req` and `rr_ptr`, with zero latency. The execute stage registers the selected results at the following edge.
- `rr_ptr` and `fixed_overflow` update at posedge `clock`.
- **Reset (asynchronous assert).**
  - Immediately: `rr_ptr` = 0 and `fixed_overflow` = 0.
  - Grant outputs are all-zero while `reset` is high, regardless of `req`.
  - Reset mid-operation discards the rotation history.
- **Deassert.** The first arbitration uses `rr_ptr` = 0.
- **Wrap.** `rr_ptr` wraps from `NUM_VAR-1` to 0. Scan order from `ptr=3` with `NUM_VAR=4` is 3, 0, 1, 2.
- **Simultaneous full load** (all `NUM_REQ` set):
  - Fixed requesters take lanes up to `N`.
  - Variable requesters are granted only if lanes remain.
  - `rr_ptr` advances only on actual variable grants.

## Configuration
- `CDB_ARB_RR_EN`
  - Defined: round-robin rotation for variable-latency requesters as above.
  - Undefined: variable requesters use fixed priority from index 0 upward. `rr_ptr` is tied to 0 and has no register. All other behaviour (fixed-first policy, overflow flag, reset) is identical.

## Test plan
All scenarios use `N`=2, `NUM_VAR`=4, `NUM_FIXED`=4, with `CDB_ARB_RR_EN` defined unless stated.
- **Reset.** Assert `reset` with `req`=8'hFF.
  - All grants are 0, `lanes_used`=0, `rr_ptr`=0, `fixed_overflow`=0.
  - After deassert, grants appear in the same cycle.
- **Round-robin rotation.** Hold `req`=8'b0000_1111.
  - Cycle 1: lane0=bit0, lane1=bit1, `var_gnt`=4'b0011, then `rr_ptr`→2.
  - Cycle 2: lane0=bit2, lane1=bit3, then `rr_ptr`→0.
- **Mixed fixed and variable.** `req`=8'b0001_0110 with `rr_ptr`=0.
  - lane0=bit4, lane1=bit1, `var_gnt`=4'b0010, `lanes_used`=2.
  - `rr_ptr`→2; bit2 is ungranted.
- **Fixed overflow.** `req`=8'b0111_0000.
  - lane0=bit4, lane1=bit5, bit6 dropped, `var_gnt`=0.
  - `fixed_overflow`=1 after the edge and stays 1 with `req`=0.
  - Pulsing `ovf_clear` returns it to 0.
- **Wrap and mid-operation reset.** Start at `rr_ptr`=3 with `req`=8'b0000_1001.
  - lane0=bit3, lane1=bit0, then `rr_ptr`→1.
  - Asserting `reset` between edges forces `rr_ptr`=0 immediately.
- **Macro undefined.** Hold `req`=8'b0000_1111 for 3 cycles.
  - Every cycle: lane0=bit0, lane1=bit1.
  - `rr_ptr` stays 0.
